conv_tile_fetch: RTL and testbench
==================================

Name: conv_tile_fetch

Overview:
- Upstream feeder for the conv_pool stage. Walks a greyscale frame in pixel memory and assembles each 4x4 window into the 128-bit tile format that conv_pool consumes.
- Presents one tile per conv_pool job (input_re pulse plus tile index), then waits for the job's completion pulse before fetching the next tile.
- Window stride is 2 in both directions, so each tile yields exactly one 2x2-max-pooled output per kernel.

Parameters:
- IMG_W, 16, frame width in pixels; even, >= 4.
- IMG_H, 16, frame height in pixels; even, >= 4.
- ADDR_W, 16, pixel-memory and tile-index address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to process a frame; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of pixel (0,0); latched on accepted start.
- mem_re  out  1  pixel-memory read enable.
- mem_addr  out  ADDR_W  pixel byte address.
- mem_rdata  in  8  pixel data, valid exactly 1 cycle after mem_re.
- image_4x4  out  128  assembled tile; pixel (r,c) at bits [r*32+c*8 +: 8], (0,0) in LSB.
- input_re  out  1  one-cycle tile-valid strobe to conv_pool.
- input_addr  out  ADDR_W  tile index, row-major, 0-based.
- conv_done  in  1  conv_pool completion pulse (wired from output_we_0).
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last tile's conv_done.

Behaviour:
- Reset values: all outputs 0; tile row (tr) and tile column (tc) counters = 0; state = IDLE.
- Reset asserted mid-frame aborts immediately: no further reads or strobes, and no frame_done.
- Tile grid: TILES_X = IMG_W/2 - 1, TILES_Y = IMG_H/2 - 1. Tile (tr,tc) covers rows 2tr..2tr+3 and cols 2tc..2tc+3. input_addr = tr*TILES_X + tc.
- FSM states:
  - IDLE: on start, latch base_addr, clear tr/tc, go to FETCH. busy rises the cycle after start.
  - FETCH: 16 consecutive cycles with mem_re=1; read counter k = 0..15. mem_addr = base + (2tr + k/4)*IMG_W + 2tc + k%4, truncated to ADDR_W (wrap-around allowed, no error). The byte returned for k is written to image_4x4 bits [(k/4)*32 + (k%4)*8 +: 8] one cycle later, using a delayed copy of k. After k=15, go to DRAIN.
  - DRAIN: mem_re=0; capture byte 15; go to ISSUE.
  - ISSUE: input_re=1 for exactly this cycle; input_addr = current tile index; go to WAIT_DONE.
  - WAIT_DONE: hold image_4x4 and input_addr stable. On conv_done: if last tile (tr = TILES_Y-1 and tc = TILES_X-1), go to FINISH. Otherwise advance tc, wrapping to 0 and incrementing tr, and go to FETCH.
  - FINISH: frame_done=1 for one cycle; go to IDLE.
- image_4x4 is only modified during FETCH and DRAIN captures. It stays stable from ISSUE through WAIT_DONE, and in IDLE it holds the last tile.
- Per-tile latency from entering FETCH to the input_re cycle: 18 cycles.
- Ignored inputs:
  - start while busy.
  - conv_done in any state other than WAIT_DONE.
  - conv_done coincident with ISSUE; it is not counted.
- start and the final conv_done can never coincide, because start is only honoured in IDLE.
- Exactly one mem_re-high cycle per pixel read: 16*TILES_X*TILES_Y reads per frame.

Test Plan:
- IMG_W=IMG_H=8, base=0, mem[i]=i; start -> tile 0: image_4x4 = 128'h1B1A1918_13121110_0B0A0908_03020100, input_addr=0, input_re pulse 18 cycles after FETCH entry.
- Same setup, tile 1 -> first row bytes 02..05, image_4x4[31:0] = 32'h05040302, input_addr=1. Tile 3 -> image_4x4[31:0] = 32'h13121110, input_addr=3.
- Full 8x8 frame, conv_done returned 40 cycles after each input_re -> 9 input_re pulses, input_addr 0..8, 144 mem_re cycles, one frame_done after the 9th conv_done, busy low the next cycle.
- start pulsed during WAIT_DONE and conv_done pulsed during FETCH -> no effect: tile sequence, read count and addresses unchanged.
- base=16'hFFF8, IMG_W=IMG_H=4 -> mem_addr sequence FFF8..FFFB, FFFC..FFFF, 0000..0003, 0004..0007 (wrap); a single tile with input_addr=0.
- rst asserted during FETCH of tile 2 -> next cycle all outputs 0 and state IDLE; no frame_done. A new start refetches from tile 0.

Source files
------------

// File: rtl/conv_tile_fetch.sv
// rtl/conv_tile_fetch.sv - walks a frame with a 4x4/stride-2 window and issues each tile to conv_pool
module conv_tile_fetch #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [127:0]      image_4x4,
  output logic              input_re,
  output logic [ADDR_W-1:0] input_addr,
  input  logic              conv_done,
  output logic              busy,
  output logic              frame_done
);

  localparam int TILES_X = IMG_W / 2 - 1;
  localparam int TILES_Y = IMG_H / 2 - 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] tr;
  logic [ADDR_W-1:0] tc;
  logic [ADDR_W-1:0] tile_idx;
  logic [3:0]        k;
  logic [3:0]        k_d;
  logic              cap_v;
  logic [ADDR_W-1:0] row;
  logic              last_tile;

  // Address arithmetic is done at ADDR_W so a frame near the top of memory wraps silently.
  assign row       = (tr << 1) + ADDR_W'(k[3:2]);
  assign mem_re    = (state == S_FETCH);
  assign mem_addr  = mem_re ? (base_q + row * ADDR_W'(IMG_W) + (tc << 1) + ADDR_W'(k[1:0]))
                            : '0;
  assign input_re  = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign frame_done = (state == S_FINISH);
  assign last_tile = (tr == ADDR_W'(TILES_Y - 1)) && (tc == ADDR_W'(TILES_X - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      tr         <= '0;
      tc         <= '0;
      tile_idx   <= '0;
      k          <= '0;
      k_d        <= '0;
      cap_v      <= 1'b0;
      image_4x4  <= '0;
      input_addr <= '0;
    end else begin
      // Read data lags mem_re by one cycle, so capture uses the delayed read index.
      cap_v <= (state == S_FETCH);
      k_d   <= k;
      if (cap_v) begin
        image_4x4[{k_d, 3'b000} +: 8] <= mem_rdata;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            tr       <= '0;
            tc       <= '0;
            tile_idx <= '0;
            k        <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          k <= k + 4'd1;
          if (k == 4'd15) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          input_addr <= tile_idx;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done) begin
            if (last_tile) begin
              state <= S_FINISH;
            end else begin
              if (tc == ADDR_W'(TILES_X - 1)) begin
                tc <= '0;
                tr <= tr + 1'b1;
              end else begin
                tc <= tc + 1'b1;
              end
              tile_idx <= tile_idx + 1'b1;
              k        <= '0;
              state    <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_fetch.sv
// tb/tb_conv_tile_fetch.sv - directed bench for conv_tile_fetch on an 8x8 frame and a wrapping 4x4 frame
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) passed++; \
    else begin \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_conv_tile_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // 8x8 instance
  logic         a_start = 1'b0;
  logic [15:0]  a_base = 16'h0000;
  logic         a_mem_re;
  logic [15:0]  a_mem_addr;
  logic [7:0]   a_rdata = 8'h00;
  logic [127:0] a_image;
  logic         a_input_re;
  logic [15:0]  a_input_addr;
  logic         a_conv_done = 1'b0;
  logic         a_busy;
  logic         a_frame_done;

  // 4x4 instance
  logic         b_start = 1'b0;
  logic [15:0]  b_base = 16'h0000;
  logic         b_mem_re;
  logic [15:0]  b_mem_addr;
  logic [7:0]   b_rdata = 8'h00;
  logic [127:0] b_image;
  logic         b_input_re;
  logic [15:0]  b_input_addr;
  logic         b_conv_done = 1'b0;
  logic         b_busy;
  logic         b_frame_done;

  conv_tile_fetch #(.IMG_W(8), .IMG_H(8), .ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base),
    .mem_re(a_mem_re), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .image_4x4(a_image), .input_re(a_input_re), .input_addr(a_input_addr),
    .conv_done(a_conv_done), .busy(a_busy), .frame_done(a_frame_done)
  );

  conv_tile_fetch #(.IMG_W(4), .IMG_H(4), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base),
    .mem_re(b_mem_re), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .image_4x4(b_image), .input_re(b_input_re), .input_addr(b_input_addr),
    .conv_done(b_conv_done), .busy(b_busy), .frame_done(b_frame_done)
  );

  // Pixel memory: each byte holds the low 8 bits of its own address.
  always @(posedge clk) begin
    if (a_mem_re) a_rdata <= a_mem_addr[7:0];
    if (b_mem_re) b_rdata <= b_mem_addr[7:0];
  end

  // Monitor for the first 8x8 frame: independent address model, strobe log, pulse counts.
  int          rd_n = 0;
  int          addr_err = 0;
  int          ir_cnt = 0;
  int          fd_cnt = 0;
  logic [15:0] ir_addr [0:15];

  always @(negedge clk) begin
    int n_t;
    int n_k;
    int exp_a;
    if (a_mem_re) begin
      n_t   = rd_n / 16;
      n_k   = rd_n % 16;
      exp_a = (2 * (n_t / 3) + n_k / 4) * 8 + 2 * (n_t % 3) + n_k % 4;
      if (a_mem_addr !== exp_a[15:0]) addr_err++;
      rd_n++;
    end
    if (a_input_re) begin
      if (ir_cnt < 16) ir_addr[ir_cnt] = a_input_addr;
      ir_cnt++;
    end
    if (a_frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  localparam logic [127:0] TILE0 = 128'h1B1A1918_13121110_0B0A0908_03020100;
  localparam logic [127:0] TILE8 = 128'h3F3E3D3C_37363534_2F2E2D2C_27262524;
  localparam logic [127:0] TILEB = 128'h07060504_03020100_FFFEFDFC_FBFAF9F8;

  initial begin
    int lat;
    int bad;
    int snap_fd;
    int snap_rd;
    logic [15:0] exp16;

    repeat (3) tick();
    `CHK("reset_ctrl", {a_mem_re, a_input_re, a_busy, a_frame_done}, 4'b0000)
    `CHK("reset_data", {a_image, a_input_addr, a_mem_addr}, 160'h0)
    rst = 1'b0;
    tick();

    // Full 8x8 frame with conv_done 40 cycles after each strobe.
    a_base  = 16'h0000;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    lat = 1;
    `CHK("busy_after_start", a_busy, 1'b1)

    for (int t = 0; t < 9; t++) begin
      while (!a_input_re && lat < 100) begin
        tick();
        lat++;
      end
      `CHK("tile_latency", lat, 18)
      `CHK("tile_addr", a_input_addr, 16'(t))
      if (t == 0) `CHK("tile0_image", a_image, TILE0)
      if (t == 1) `CHK("tile1_row0", a_image[31:0], 32'h05040302)
      if (t == 3) begin
        `CHK("tile3_row0", a_image[31:0], 32'h13121110)
        `CHK("tile3_row3", a_image[127:96], 32'h2B2A2928)
      end
      if (t == 8) `CHK("tile8_image", a_image, TILE8)

      if (t == 0) begin
        repeat (10) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        `CHK("wait_hold_image", a_image, TILE0)
        `CHK("wait_hold_addr", a_input_addr, 16'h0000)
        repeat (29) tick();
      end else begin
        repeat (40) tick();
      end
      a_conv_done = 1'b1;
      tick();
      a_conv_done = 1'b0;
      lat = 1;

      if (t == 0) begin
        repeat (4) tick();
        `CHK("spurious_done_in_fetch", a_mem_re, 1'b1)
        a_conv_done = 1'b1;
        tick();
        a_conv_done = 1'b0;
        lat += 5;
      end
    end

    `CHK("frame_done_pulse", a_frame_done, 1'b1)
    tick();
    `CHK("idle_after_frame", {a_busy, a_frame_done}, 2'b00)
    repeat (3) tick();
    `CHK("frame_done_count", fd_cnt, 1)
    `CHK("input_re_count", ir_cnt, 9)
    `CHK("mem_re_count", rd_n, 144)
    `CHK("mem_addr_sequence", addr_err, 0)
    bad = 0;
    for (int i = 0; i < 9; i++) if (ir_addr[i] !== 16'(i)) bad++;
    `CHK("input_addr_sequence", bad, 0)
    `CHK("idle_holds_last_tile", a_image, TILE8)

    // 4x4 frame at the top of the address space.
    b_base  = 16'hFFF8;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      exp16 = 16'hFFF8 + 16'(k);
      if (!b_mem_re || b_mem_addr !== exp16) bad++;
      tick();
    end
    `CHK("wrap_addr_sequence", bad, 0)
    `CHK("wrap_drain_no_read", b_mem_re, 1'b0)
    lat = 0;
    while (!b_input_re && lat < 20) begin
      tick();
      lat++;
    end
    `CHK("wrap_issue", b_input_re, 1'b1)
    `CHK("wrap_input_addr", b_input_addr, 16'h0000)
    `CHK("wrap_image", b_image, TILEB)
    repeat (5) tick();
    b_conv_done = 1'b1;
    tick();
    b_conv_done = 1'b0;
    `CHK("wrap_frame_done", b_frame_done, 1'b1)
    tick();
    `CHK("wrap_idle", b_busy, 1'b0)

    // Reset during the fetch of tile 2, then a clean restart.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      lat = 0;
      while (!a_input_re && lat < 100) begin
        tick();
        lat++;
      end
      `CHK("abort_run_addr", a_input_addr, 16'(t))
      repeat (3) tick();
      a_conv_done = 1'b1;
      tick();
      a_conv_done = 1'b0;
    end
    repeat (3) tick();
    `CHK("abort_in_fetch", a_mem_re, 1'b1)
    snap_fd = fd_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    `CHK("abort_ctrl", {a_mem_re, a_input_re, a_busy, a_frame_done}, 4'b0000)
    `CHK("abort_data", {a_image, a_input_addr, a_mem_addr}, 160'h0)
    snap_rd = rd_n;
    repeat (30) tick();
    `CHK("abort_no_frame_done", fd_cnt, snap_fd)
    `CHK("abort_no_reads", rd_n, snap_rd)

    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    lat = 1;
    `CHK("restart_first_read", {a_mem_re, a_mem_addr}, 17'h1_0000)
    while (!a_input_re && lat < 100) begin
      tick();
      lat++;
    end
    `CHK("restart_latency", lat, 18)
    `CHK("restart_addr", a_input_addr, 16'h0000)
    `CHK("restart_image", a_image, TILE0)

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
